// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared widths, fault word and response type for imem_sync
package imem_pkg;

  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_ADDR_W = 16;
  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD = 16'h0000;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] com;
    logic                   fault;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - 2-entry in-order response buffer with flush
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter type T = imem_rsp_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  input  logic       flush,
  output T           head,
  output logic [1:0] count,
  output logic [1:0] count_next
);

  T           slot_q [2];
  T           slot_d [2];
  T           head_q, head_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = push_data;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
    // Head is registered; with nothing buffered it keeps the last word handed out.
    head_d = (count_d != 2'd0) ? slot_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q   <= '{default: '0};
      head_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      slot_q   <= slot_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head       = head_q;
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - synchronous instruction memory with fetch handshake,
// program-load port, redirect flush and out-of-range fault reporting
module imem_sync
  import imem_pkg::*;
#(
  parameter int                DATA_W    = IMEM_DATA_W,
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(IMEM_NOP_WORD),
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_com,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] com;
    logic              fault;
  } rsp_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic       s1_valid_q, s1_valid_d;
  rsp_t       s1_rsp_q, s1_rsp_d;
  logic       busy_q, busy_d;
  logic       req_fire, rd_in_range, ld_in_range, rsp_pop;
  logic [1:0] fifo_count, fifo_count_next;
  rsp_t       fifo_head;

  always_comb begin
    rd_in_range = (32'(req_addr) < 32'(DEPTH));
    ld_in_range = (32'(ld_addr) < 32'(DEPTH));
    // Slots already promised (S1 plus buffered) must leave room for one more.
    req_ready   = !ld_en && !flush &&
                  (({1'b0, fifo_count} + {2'b00, s1_valid_q}) < 3'd2);
    req_fire    = req_valid && req_ready;
    s1_valid_d  = req_fire;
    s1_rsp_d    = s1_rsp_q;
    if (req_fire) begin
      s1_rsp_d.com   = rd_in_range ? mem_q[req_addr[IDX_W-1:0]] : NOP_WORD;
      s1_rsp_d.fault = !rd_in_range;
    end
    rsp_pop = (fifo_count != 2'd0) && rsp_ready;
    busy_d  = s1_valid_d || (fifo_count_next != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst_n && ld_en && ld_in_range) begin
      mem_q[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_rsp_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rsp_q   <= s1_rsp_d;
      busy_q     <= busy_d;
    end
  end

  imem_rsp_fifo #(
    .T (rsp_t)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (s1_valid_q && !flush),
    .push_data  (s1_rsp_q),
    .pop        (rsp_pop),
    .flush      (flush),
    .head       (fifo_head),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_com   = fifo_head.com;
  assign rsp_fault = fifo_head.fault;
  assign busy      = busy_q;

endmodule

// File: tb/tb_imem_sync.sv
// tb/tb_imem_sync.sv - directed and randomized bench for imem_sync against
// an ordered outstanding-response model
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_com;
  logic        rsp_fault;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = 16'd0;
  logic [15:0] ld_data = 16'd0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n_pop = 0;
  int base;

  logic [15:0] model_mem [256];
  logic [16:0] exp_q [$];
  logic [15:0] load_w [8];

  imem_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_com   (rsp_com),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model_rsp(input logic [15:0] a);
    if (a < 16'd256) return {1'b0, model_mem[a[7:0]]};
    return {1'b1, 16'h0000};
  endfunction

  function automatic logic [15:0] pick_addr();
    int r = $urandom_range(0, 9);
    if (r < 8) return 16'(r);
    if (r == 8) return 16'd255;
    return 16'(256 + $urandom_range(0, 65279));
  endfunction

  // Transaction-level scoreboard: outstanding = accepted minus consumed.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("req_ready", {31'd0, req_ready},
            {31'd0, (!ld_en && !flush && exp_q.size() < 2)});
      check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() == 0) check("rsp_valid_empty", {31'd0, rsp_valid}, 32'd0);
      if (exp_q.size() == 2) check("rsp_valid_full", {31'd0, rsp_valid}, 32'd1);
      if (rsp_valid && rsp_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        end else begin
          check("rsp_com", {16'd0, rsp_com}, {16'd0, exp_q[0][15:0]});
          check("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_q[0][16]});
          void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      if (req_valid && req_ready) exp_q.push_back(model_rsp(req_addr));
      if (ld_en && ld_addr < 16'd256) model_mem[ld_addr[7:0]] = ld_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a);
    logic done = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < 20 && !done; k++) begin
      #2;
      done = req_ready;
      cyc();
    end
    req_valid = 1'b0;
    check("issue_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    logic idle = 1'b0;
    req_valid = 1'b0;
    ld_en     = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && !idle; k++) begin
      cyc();
      idle = !busy && !rsp_valid;
    end
    check("drain", {31'd0, idle}, 32'd1);
  endtask

  initial begin
    load_w[0] = 16'h1111;
    load_w[1] = 16'h2222;
    load_w[2] = 16'h3333;
    load_w[3] = 16'h4444;
    for (int i = 4; i < 8; i++) load_w[i] = 16'($urandom);

    cyc();
    cyc();
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_com", {16'd0, rsp_com}, 32'd0);
    check("rst_fault", {31'd0, rsp_fault}, 32'd0);
    rst_n = 1'b1;

    // Program load while a request is pending: it must be held off.
    req_valid = 1'b1;
    req_addr  = 16'd0;
    for (int i = 0; i < 10; i++) begin
      ld_en   = 1'b1;
      ld_addr = (i < 8) ? 16'(i) : ((i == 8) ? 16'd257 : 16'd255);
      ld_data = (i < 8) ? load_w[i] : ((i == 8) ? 16'hBEEF : 16'h5A5A);
      #2;
      check("load_blocks_req", {31'd0, req_ready}, 32'd0);
      cyc();
    end
    ld_en     = 1'b0;
    req_valid = 1'b0;

    // Stream 0..3 with consumer ready; first word one cycle after first accept.
    rsp_ready = 1'b1;
    base      = n_pop;
    req_valid = 1'b1;
    req_addr  = 16'd0;
    cyc();
    check("lat_s1_not_visible", {31'd0, rsp_valid}, 32'd0);
    issue(16'd1);
    check("lat_first_valid", {31'd0, rsp_valid}, 32'd1);
    check("lat_first_com", {16'd0, rsp_com}, 32'h1111);
    issue(16'd2);
    issue(16'd3);
    wait_idle();
    check("t1_pops", n_pop - base, 32'd4);
    check("t1_last_held", {16'd0, rsp_com}, 32'h4444);

    // Backpressure: two outstanding, third refused until a pop.
    rsp_ready = 1'b0;
    base      = n_pop;
    issue(16'd0);
    issue(16'd1);
    req_valid = 1'b1;
    req_addr  = 16'd2;
    #2;
    check("t2_full_ready", {31'd0, req_ready}, 32'd0);
    cyc();
    check("t2_head", {16'd0, rsp_com}, 32'h1111);
    rsp_ready = 1'b1;
    issue(16'd2);
    wait_idle();
    check("t2_pops", n_pop - base, 32'd3);
    check("t2_last", {16'd0, rsp_com}, 32'h3333);

    // Faults and range boundaries; 257 must not alias onto word 1.
    issue(16'd300);
    wait_idle();
    check("t3_fault_com", {16'd0, rsp_com}, 32'h0000);
    check("t3_fault_flag", {31'd0, rsp_fault}, 32'd1);
    issue(16'd1);
    wait_idle();
    check("t3_after_fault", {16'd0, rsp_com}, 32'h2222);
    check("t3_after_flag", {31'd0, rsp_fault}, 32'd0);
    issue(16'd256);
    wait_idle();
    check("t3_256_fault", {31'd0, rsp_fault}, 32'd1);
    issue(16'd255);
    wait_idle();
    check("t3_255_com", {16'd0, rsp_com}, 32'h5A5A);

    // Flush with a full buffer and a competing request.
    rsp_ready = 1'b0;
    issue(16'd0);
    issue(16'd1);
    cyc();
    check("t4_full", {31'd0, rsp_valid}, 32'd1);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'd3;
    #2;
    check("t4_flush_ready", {31'd0, req_ready}, 32'd0);
    cyc();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("t4_valid_after", {31'd0, rsp_valid}, 32'd0);
    check("t4_busy_after", {31'd0, busy}, 32'd0);
    rsp_ready = 1'b1;
    base      = n_pop;
    issue(16'd3);
    wait_idle();
    check("t4_com", {16'd0, rsp_com}, 32'h4444);
    check("t4_pops", n_pop - base, 32'd1);

    // Load behind an in-flight read of the same word.
    rsp_ready = 1'b0;
    issue(16'd2);
    ld_en     = 1'b1;
    ld_addr   = 16'd2;
    ld_data   = 16'hABCD;
    req_valid = 1'b1;
    req_addr  = 16'd2;
    #2;
    check("t5_ld_ready", {31'd0, req_ready}, 32'd0);
    cyc();
    ld_en     = 1'b0;
    req_valid = 1'b0;
    wait_idle();
    check("t5_old_word", {16'd0, rsp_com}, 32'h3333);
    issue(16'd2);
    wait_idle();
    check("t5_new_word", {16'd0, rsp_com}, 32'hABCD);

    // Reset mid-stream; memory contents survive.
    rsp_ready = 1'b0;
    issue(16'd0);
    issue(16'd1);
    cyc();
    rst_n = 1'b0;
    cyc();
    check("t6_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_com", {16'd0, rsp_com}, 32'd0);
    rst_n = 1'b1;
    issue(16'd0);
    wait_idle();
    check("t6_mem_kept", {16'd0, rsp_com}, 32'h1111);

    // Random traffic: requests, loads, flushes and consumer stalls.
    for (int n = 0; n < 400; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      ld_en     = ($urandom_range(0, 11) == 0);
      ld_addr   = pick_addr();
      ld_data   = 16'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = pick_addr();
      cyc();
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
